// File: rtl/exec_track.sv
// In-order execute-stage result tracker: circular buffer of in-flight writes,
// operand hazard/forward queries and program-order writeback. Build option: EXEC_TRACK_FWD_EN.
module exec_track #(
   parameter int DEPTH     = 4,
   parameter int NUM_UNITS = 4,
   parameter int LAT_W     = 4,
   parameter int DATA_W    = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            issue_valid,
   output logic                            issue_ready,
   input  logic [4:0]                      issue_rd,
   input  logic                            issue_fmode,
   input  logic                            issue_wr,
   input  logic [LAT_W-1:0]                issue_lat,
   input  logic [$clog2(NUM_UNITS)-1:0]    issue_unit,
   input  logic [DATA_W-1:0]               issue_data,
   input  logic [NUM_UNITS*DATA_W-1:0]     unit_data,
   input  logic                            ext_done,
   input  logic [DATA_W-1:0]               ext_data,
   input  logic [4:0]                      rs_no,
   input  logic [4:0]                      rt_no,
   input  logic                            rs_fmode,
   input  logic                            rt_fmode,
   output logic                            rs_hazard,
   output logic                            rt_hazard,
   output logic                            rs_fwd_en,
   output logic                            rt_fwd_en,
   output logic [DATA_W-1:0]               rs_fwd,
   output logic [DATA_W-1:0]               rt_fwd,
   output logic                            wb_valid,
   output logic                            wb_fmode,
   output logic [4:0]                      wb_reg,
   output logic [DATA_W-1:0]               wb_data,
   output logic [$clog2(DEPTH):0]          count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int UNIT_W = $clog2(NUM_UNITS);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [LAT_W-1:0] LAT_EXT = '1;

   logic [DEPTH-1:0]  ent_valid;
   logic [DEPTH-1:0]  ent_fmode;
   logic [DEPTH-1:0]  ent_wr;
   logic [DEPTH-1:0]  ent_ext;
   logic [DEPTH-1:0]  ent_done;
   logic [4:0]        ent_rd   [DEPTH];
   logic [UNIT_W-1:0] ent_unit [DEPTH];
   logic [LAT_W-1:0]  ent_cnt  [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;

   logic              issue_fire;
   logic              retire_fire;
   logic              ext_hit;
   logic [PTR_W-1:0]  ext_idx;
   logic [DEPTH-1:0]  rs_match;
   logic [DEPTH-1:0]  rt_match;

   assign issue_ready = (count < DEPTH_C);
   assign issue_fire  = issue_valid && issue_ready;
   assign retire_fire = ent_valid[head] && ent_done[head];

   // Scan youngest-to-oldest so the oldest pending external entry is the last hit.
   always_comb begin
      logic [PTR_W-1:0] idx;
      ext_hit = 1'b0;
      ext_idx = '0;
      idx     = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         idx = head + PTR_W'(i);
         if (ent_valid[idx] && ent_ext[idx] && !ent_done[idx]) begin
            ext_hit = 1'b1;
            ext_idx = idx;
         end
      end
   end

   // Integer register 0 is hard-wired, so writes to it never create a dependency.
   always_comb begin
      rs_match = '0;
      rt_match = '0;
      for (int j = 0; j < DEPTH; j++) begin
         rs_match[j] = ent_valid[j] && ent_wr[j] && (ent_fmode[j] == rs_fmode) &&
                       (ent_rd[j] == rs_no) && (ent_fmode[j] || (ent_rd[j] != 5'd0));
         rt_match[j] = ent_valid[j] && ent_wr[j] && (ent_fmode[j] == rt_fmode) &&
                       (ent_rd[j] == rt_no) && (ent_fmode[j] || (ent_rd[j] != 5'd0));
      end
   end

`ifdef EXEC_TRACK_FWD_EN
   // Walk oldest-to-youngest so the youngest matching entry decides the answer.
   always_comb begin
      logic             rs_hit;
      logic             rt_hit;
      logic [PTR_W-1:0] rs_sel;
      logic [PTR_W-1:0] rt_sel;
      logic [PTR_W-1:0] idx;
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      rs_sel = '0;
      rt_sel = '0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (rs_match[idx]) begin
            rs_hit = 1'b1;
            rs_sel = idx;
         end
         if (rt_match[idx]) begin
            rt_hit = 1'b1;
            rt_sel = idx;
         end
      end
      rs_hazard = rs_hit && !ent_done[rs_sel];
      rs_fwd_en = rs_hit && ent_done[rs_sel];
      rs_fwd    = rs_fwd_en ? ent_data[rs_sel] : '0;
      rt_hazard = rt_hit && !ent_done[rt_sel];
      rt_fwd_en = rt_hit && ent_done[rt_sel];
      rt_fwd    = rt_fwd_en ? ent_data[rt_sel] : '0;
   end
`else
   // Without forwarding any in-flight writer stalls the operand until writeback.
   assign rs_hazard = |rs_match;
   assign rt_hazard = |rt_match;
   assign rs_fwd_en = 1'b0;
   assign rt_fwd_en = 1'b0;
   assign rs_fwd    = '0;
   assign rt_fwd    = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent_done  <= '0;
         ent_ext   <= '0;
         wb_valid  <= 1'b0;
         wb_fmode  <= 1'b0;
         wb_reg    <= '0;
         wb_data   <= '0;
      end else begin
         wb_valid <= 1'b0;

         for (int j = 0; j < DEPTH; j++) begin
            if (ent_valid[j] && !ent_done[j] && !ent_ext[j]) begin
               ent_cnt[j] <= ent_cnt[j] - LAT_W'(1);
               if (ent_cnt[j] == LAT_W'(1)) begin
                  ent_data[j] <= unit_data[int'(ent_unit[j]) * DATA_W +: DATA_W];
                  ent_done[j] <= 1'b1;
               end
            end
         end

         if (ext_done && ext_hit) begin
            ent_data[ext_idx] <= ext_data;
            ent_done[ext_idx] <= 1'b1;
         end

         // The tail slot is always free when issue is accepted, so no field conflicts.
         if (issue_fire) begin
            ent_valid[tail] <= 1'b1;
            ent_rd[tail]    <= issue_rd;
            ent_fmode[tail] <= issue_fmode;
            ent_wr[tail]    <= issue_wr;
            ent_unit[tail]  <= issue_unit;
            ent_cnt[tail]   <= issue_lat;
            ent_ext[tail]   <= (issue_lat == LAT_EXT);
            ent_done[tail]  <= (issue_lat == '0);
            ent_data[tail]  <= issue_data;
            tail            <= tail + PTR_W'(1);
         end

         if (retire_fire) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PTR_W'(1);
            wb_valid        <= ent_wr[head];
            if (ent_wr[head]) begin
               wb_fmode <= ent_fmode[head];
               wb_reg   <= ent_rd[head];
               wb_data  <= ent_data[head];
            end
         end

         unique case ({issue_fire, retire_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
